// File: rtl/video_pkg.sv
// Shared video timing package: default 640x480@60 timing constants,
// total-period helper and the timing generator FSM state type.
package video_pkg;

   // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Full period of one axis: visible + front porch + sync + back porch
   function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF); // 800
   localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF); // 525

   typedef enum logic {
      WAIT_LOCK = 1'b0,
      RUN       = 1'b1
   } vga_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (PLL lock).
// With VGA_TIMING_PIXREQ_EN defined, the first-stage value is also exported
// as a one-clock look-ahead of q for the pixel-request prefetch logic.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
`ifdef VGA_TIMING_PIXREQ_EN
   output logic q_early,
`endif
   output logic q
);

   logic meta_q;
   logic sync_q;

   // two back-to-back flops to resolve metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
`ifdef VGA_TIMING_PIXREQ_EN
   assign q_early = meta_q;
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: synchronised PLL-lock gating, h/v counters and
// registered sync/de/pixel-coordinate/pulse outputs (latency 1 from counters).
// Optional feature macro: VGA_TIMING_PIXREQ_EN adds pix_req/req_x/req_y,
// a one-clock-early copy of de/pix_x/pix_y for frame-buffer prefetch.
module vga_timing_gen
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_TIMING_PIXREQ_EN
   ,
   output logic       pix_req,
   output logic [9:0] req_x,
   output logic [9:0] req_y
`endif
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic       locked_s;
   logic       run;
   logic       de_in;
   vga_state_e state_q, state_d;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       de_q, de_d;
   logic [9:0] pix_x_q, pix_x_d;
   logic [9:0] pix_y_q, pix_y_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

`ifdef VGA_TIMING_PIXREQ_EN
   logic       lock_early;
`endif

   sync_2ff u_lock_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (pll_locked),
`ifdef VGA_TIMING_PIXREQ_EN
      .q_early (lock_early),
`endif
      .q       (locked_s)
   );

   // lock FSM: enter RUN on lock, drop back to WAIT_LOCK the moment lock is lost
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LOCK: if (locked_s)  state_d = RUN;
         RUN:       if (!locked_s) state_d = WAIT_LOCK;
         default:   state_d = WAIT_LOCK;
      endcase
   end

   // the clock in which the FSM moves to/stays in RUN is a RUN clock, so the
   // first one after lock starts from the parked origin (0,0)
   assign run = (state_d == RUN);

   // pixel/line counters: advance on RUN clocks, parked at the origin otherwise
   always_comb begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (run) begin
         if (h_cnt_q == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
         end
      end
   end

   // output decode from the current counters; all outputs inactive outside RUN
   always_comb begin
      de_in         = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      de_d          = de_in;
      pix_x_d       = de_in ? h_cnt_q : '0;
      pix_y_d       = de_in ? v_cnt_q : '0;
      hsync_d       = !(run && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
      vsync_d       = !(run && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
      line_start_d  = run && (h_cnt_q == '0);
      frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // state, counters and output registers; syncs reset high so release cannot glitch them low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_LOCK;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_PIXREQ_EN
   logic       pix_req_q, pix_req_d;
   logic [9:0] req_x_q, req_x_d;
   logic [9:0] req_y_q, req_y_d;

   // look one clock ahead: lock_early is next clock's locked_s, h/v_cnt_d next clock's counters
   always_comb begin
      pix_req_d = lock_early && (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
      req_x_d   = pix_req_d ? h_cnt_d : '0;
      req_y_d   = pix_req_d ? v_cnt_d : '0;
   end

   // prefetch request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_req_q <= 1'b0;
         req_x_q   <= '0;
         req_y_q   <= '0;
      end else begin
         pix_req_q <= pix_req_d;
         req_x_q   <= req_x_d;
         req_y_q   <= req_y_d;
      end
   end

   assign pix_req = pix_req_q;
   assign req_x   = req_x_q;
   assign req_y   = req_y_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced timing set so that
// several frames fit in a short run. A time-based reference model pushes the
// expected output word at each clock edge; it is popped and compared on the
// following falling edge. Directed steps add period/width/latency checks.
module tb_vga_timing_gen;

   localparam int HA  = 16;
   localparam int HFP = 4;
   localparam int HSY = 8;
   localparam int HBP = 4;
   localparam int HT  = HA + HFP + HSY + HBP;
   localparam int VA  = 12;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int VT  = VA + VFP + VSY + VBP;
   localparam int FRAME  = HT * VT;
   localparam int DROP_X = 10;
   localparam int DROP_Y = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       hsync, vsync, de, line_start, frame_start;
   logic [9:0] pix_x, pix_y;
`ifdef VGA_TIMING_PIXREQ_EN
   logic       pix_req;
   logic [9:0] req_x, req_y;
   logic [20:0] req_exp_q[$];
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [24:0] exp_q[$];
   logic lk1 = 1'b0;
   logic lk2 = 1'b0;
   int t_pos = 0;

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .line_start  (line_start),
`ifdef VGA_TIMING_PIXREQ_EN
      .pix_req     (pix_req),
      .req_x       (req_x),
      .req_y       (req_y),
`endif
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected {hsync,vsync,de,pix_x,pix_y,line_start,frame_start} for run position t
   function automatic logic [24:0] model_out(input logic run, input int t);
      int h, v;
      logic d;
      h = t % HT;
      v = (t / HT) % VT;
      if (!run) return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
      d = (h < HA) && (v < VA);
      return {!((h >= HA + HFP) && (h < HA + HFP + HSY)),
              !((v >= VA + VFP) && (v < VA + VFP + VSY)),
              d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0,
              (h == 0), (h == 0) && (v == 0)};
   endfunction

`ifdef VGA_TIMING_PIXREQ_EN
   function automatic logic [20:0] model_req(input logic run, input int t);
      int h, v;
      logic d;
      h = t % HT;
      v = (t / HT) % VT;
      d = run && (h < HA) && (v < VA);
      return {d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0};
   endfunction
`endif

   // one clock: model the edge, push expectation, compare on the falling edge
   task automatic tick();
      logic [24:0] exp_v;
      logic [24:0] obs_v;
      logic run_now;
      @(posedge clk);
      run_now = lk2;
      exp_q.push_back(model_out(run_now, t_pos));
      if (run_now) t_pos++;
      else t_pos = 0;
      lk2 = lk1;
      lk1 = pll_locked;
`ifdef VGA_TIMING_PIXREQ_EN
      req_exp_q.push_back(model_req(lk2, t_pos));
`endif
      @(negedge clk);
      cyc++;
      obs_v = {hsync, vsync, de, pix_x, pix_y, line_start, frame_start};
      exp_v = exp_q.pop_front();
      check($sformatf("outputs@%0d", cyc), 32'(obs_v), 32'(exp_v));
`ifdef VGA_TIMING_PIXREQ_EN
      check($sformatf("pix_req@%0d", cyc), 32'({pix_req, req_x, req_y}), 32'(req_exp_q.pop_front()));
`endif
   endtask

   initial begin
      int n;
      int fs_prev, ls_prev, de_line, de_frame, vs_low, hs_fall, frames;
      logic prev_hs, prev_vs, found;

      // reset held with PLL already locked: everything idle
      rst_n = 1'b0;
      pll_locked = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_de", 32'(de), 32'd0);
      check("rst_pulses", 32'({line_start, frame_start}), 32'd0);
      check("rst_pix", 32'({pix_x, pix_y}), 32'd0);
      $display("[TB] reset: hsync=%0b vsync=%0b de=%0b", hsync, vsync, de);

      // release reset: frame_start after 2 sync flops + 1 output register
      rst_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!frame_start && n < 10);
      check("fs_latency", 32'(n), 32'd3);
      $display("[TB] reset release: frame_start after %0d clocks", n);

      // free run two frames: periods, de counts, sync placement and widths
      fs_prev = cyc; ls_prev = cyc;
      de_line = de ? 1 : 0; de_frame = de ? 1 : 0;
      vs_low = 0; hs_fall = -1; frames = 0;
      prev_hs = hsync; prev_vs = vsync;
      repeat (2 * FRAME) begin
         tick();
         if (line_start) begin
            check("line_period", 32'(cyc - ls_prev), 32'(HT));
            if (de_line != 0) check("de_per_line", 32'(de_line), 32'(HA));
            ls_prev = cyc;
            de_line = 0;
         end
         if (frame_start) begin
            check("frame_period", 32'(cyc - fs_prev), 32'(FRAME));
            check("de_per_frame", 32'(de_frame), 32'(HA * VA));
            check("vsync_low_clocks", 32'(vs_low), 32'(VSY * HT));
            $display("[TB] frame: period=%0d de=%0d vsync_low=%0d", cyc - fs_prev, de_frame, vs_low);
            fs_prev = cyc;
            de_frame = 0;
            vs_low = 0;
            frames++;
         end
         if (de) begin de_line++; de_frame++; end
         if (!vsync) vs_low++;
         if (prev_hs && !hsync) begin
            check("hsync_fall_ofs", 32'(cyc - ls_prev), 32'(HA + HFP));
            hs_fall = cyc;
         end
         if (!prev_hs && hsync && hs_fall >= 0) check("hsync_width", 32'(cyc - hs_fall), 32'(HSY));
         if (prev_vs && !vsync) check("vsync_fall_ofs", 32'(cyc - fs_prev), 32'((VA + VFP) * HT));
         prev_hs = hsync;
         prev_vs = vsync;
      end
      check("frames_seen", 32'(frames), 32'd2);

      // drop lock mid-frame at (DROP_X, DROP_Y)
      n = 0;
      do begin tick(); n++; end
         while (!(de && pix_x == 10'(DROP_X) && pix_y == 10'(DROP_Y)) && n < 2 * FRAME);
      found = de && (pix_x == 10'(DROP_X)) && (pix_y == 10'(DROP_Y));
      check("drop_point_reached", 32'(found), 32'd1);
      pll_locked = 1'b0;
      repeat (3) tick();
      check("drop_de", 32'(de), 32'd0);
      check("drop_syncs", 32'({hsync, vsync}), 32'd3);
      check("drop_pix", 32'({pix_x, pix_y}), 32'd0);
      $display("[TB] lock drop: de=%0b hsync=%0b vsync=%0b after 3 clocks", de, hsync, vsync);
      repeat (6) tick();
      check("unlocked_idle", 32'({de, line_start, frame_start}), 32'd0);

      // relock: fresh frame from the origin
      pll_locked = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!frame_start && n < 10);
      check("relock_fs_latency", 32'(n), 32'd3);
      n = 0;
      while (!de && n < FRAME) begin tick(); n++; end
      check("relock_first_de", 32'(de), 32'd1);
      check("relock_first_pix", 32'({pix_x, pix_y}), 32'd0);
      $display("[TB] relock: first de at x=%0d y=%0d", pix_x, pix_y);
      repeat (HT) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 25 MHz pixel clock; one clock, reset asynchronous active-low.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pll_locked, input, 1, PLL lock status, asynchronous to clk.
REQ-012 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-014 SHALL have port de, output, 1, display enable, high in the visible region.
REQ-015 SHALL have port pix_x, output, 10, column of the current pixel.
REQ-016 SHALL have port pix_y, output, 10, line of the current pixel.
REQ-017 SHALL have port line_start, output, 1, one-clock pulse at the start of each line.
REQ-018 SHALL have port frame_start, output, 1, one-clock pulse at the start of each frame.

Function
REQ-019 SHALL synchronise pll_locked through two flops (locked_s) before any use.
REQ-020 SHALL run h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800); it wraps to 0, and v_cnt increments on that wrap.
REQ-021 SHALL run v_cnt 0..V_TOTAL-1 (V_TOTAL=525); it wraps to 0 when h_cnt and v_cnt are both at maximum.
REQ-022 SHALL run a two-state FSM: WAIT_LOCK (counters held at 0, outputs inactive), then RUN once locked_s=1; RUN returns to WAIT_LOCK as soon as locked_s=0, mid-frame included.
REQ-023 SHALL register all outputs, so they reflect the counter values one clock after those values occur (latency 1).
REQ-024 SHALL drive de=1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 SHALL drive pix_x=h_cnt and pix_y=v_cnt when de=1, and 0 otherwise.
REQ-026 SHALL drive hsync=0 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-027 SHALL drive vsync=0 for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-028 SHALL pulse line_start when h_cnt=0 in RUN.
REQ-029 SHALL pulse frame_start when h_cnt=0 and v_cnt=0 in RUN.
REQ-030 SHALL resume with the first RUN clock at h_cnt=0, v_cnt=0, so frame_start fires one clock after re-entering RUN.

Reset
REQ-031 SHALL, while rst_n=0, force: FSM=WAIT_LOCK; counters and sync flops=0; hsync=1, vsync=1; de, pix_x, pix_y, line_start, frame_start=0.
REQ-032 SHALL release reset without glitching hsync or vsync low.

Configuration
REQ-033 SHALL, with VGA_TIMING_PIXREQ_EN defined, add outputs pix_req (1 bit), req_x (10 bits) and req_y (10 bits).
REQ-034 SHALL, with VGA_TIMING_PIXREQ_EN defined, assert pix_req exactly one clock before de, carrying the x/y de will present next clock, for frame-buffer prefetch.
REQ-035 SHALL, without VGA_TIMING_PIXREQ_EN, omit those ports and logic; all other behaviour is identical.

Structure
REQ-036 SHALL place the default timing constants, H_TOTAL/V_TOTAL derivation and the FSM state enum in shared package video_pkg.
REQ-037 SHALL implement the two-flop lock synchroniser as sub-module sync_2ff.

Verification
REQ-038 SHALL check: rst_n=0 with pll_locked=1 -> hsync=vsync=1, de=0 and no pulses; frame_start arrives 3 clocks after rst_n rises (2 sync flops plus 1 output register).
REQ-039 SHALL check: free run for 2 frames -> consecutive frame_start pulses exactly 420000 clocks apart, and line_start every 800 clocks.
REQ-040 SHALL check: within one line -> de high for 640 clocks; hsync goes low 656 clocks after line_start and stays low for 96 clocks.
REQ-041 SHALL check: one full frame -> de count 307200; vsync low for 1600 clocks, starting at line 490.
REQ-042 SHALL check: pll_locked dropped at line 200, pixel 300 -> outputs inactive within 3 clocks; on relock, a fresh frame_start occurs and pix_x=pix_y=0 on the first de.
REQ-043 SHALL check, with VGA_TIMING_PIXREQ_EN defined: pix_req precedes de by exactly 1 clock, and req_x/req_y equal the next clock's pix_x/pix_y for all 307200 pixels.
